// File: rtl/window_gen_3x3_if.sv
// Pixel-stream input and 3x3 window output bundle for window_gen_3x3.
// The master side feeds pixels and consumes windows; the slave side is the window generator.
`timescale 1ns/1ps
interface window_gen_3x3_if #(
    parameter int LUMA_BITS  = 8,
    parameter int COORD_BITS = 10
);
    logic [COORD_BITS-1:0]               img_width;
    logic [COORD_BITS-1:0]               img_height;
    logic                                pix_valid;
    logic                                pix_sof;
    logic [LUMA_BITS-1:0]                pix_data;
    logic [2:0][2:0][LUMA_BITS-1:0]      window;
    logic                                win_advance;
    logic                                win_valid;
    logic [COORD_BITS-1:0]               win_x;
    logic [COORD_BITS-1:0]               win_y;
    logic                                frame_done;
    logic                                sync_err;

    modport master (
        output img_width, img_height, pix_valid, pix_sof, pix_data,
        input  window, win_advance, win_valid, win_x, win_y, frame_done, sync_err
    );

    modport slave (
        input  img_width, img_height, pix_valid, pix_sof, pix_data,
        output window, win_advance, win_valid, win_x, win_y, frame_done, sync_err
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Two-line-buffer 3x3 neighbourhood generator for a raster luma stream.
// Emits a registered window, advance strobe, validity flag and centre coordinates per accepted pixel.
`timescale 1ns/1ps
module window_gen_3x3 #(
    parameter int LUMA_BITS  = 8,
    parameter int MAX_WIDTH  = 640,
    parameter int COORD_BITS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    window_gen_3x3_if.slave  bus
);
    localparam int LB_AW = $clog2(MAX_WIDTH);
    localparam logic [COORD_BITS-1:0] C_MIN_DIM = COORD_BITS'(3);
    localparam logic [COORD_BITS-1:0] C_MAX_W   = COORD_BITS'(MAX_WIDTH);
    localparam logic [COORD_BITS-1:0] C_ONE     = COORD_BITS'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                          r_state;
    logic [COORD_BITS-1:0]           r_col, r_row;
    logic [COORD_BITS-1:0]           r_w_last, r_h_last;
    logic [2:0][2:0][LUMA_BITS-1:0]  r_window;
    logic                            r_win_advance, r_win_valid, r_frame_done, r_sync_err;
    logic [COORD_BITS-1:0]           r_win_x, r_win_y;
    logic [LUMA_BITS-1:0]            r_lb_old [MAX_WIDTH];
    logic [LUMA_BITS-1:0]            r_lb_mid [MAX_WIDTH];

    logic                  w_dims_ok, w_sof_pix, w_good_sof, w_bad_sof, w_accept;
    logic [COORD_BITS-1:0] w_cur_col, w_cur_row, w_w_last, w_h_last;
    logic                  w_last_col, w_last_pix;
    logic [LB_AW-1:0]      w_addr;
    logic [LUMA_BITS-1:0]  w_lb_old, w_lb_mid;

    assign w_dims_ok  = (bus.img_width >= C_MIN_DIM) && (bus.img_width <= C_MAX_W)
                     && (bus.img_height >= C_MIN_DIM);
    assign w_sof_pix  = bus.pix_valid && bus.pix_sof;
    assign w_good_sof = w_sof_pix && w_dims_ok;
    assign w_bad_sof  = w_sof_pix && !w_dims_ok;
    assign w_accept   = w_good_sof || (bus.pix_valid && !bus.pix_sof && r_state == ACTIVE);

    // A good SOF restarts at (0,0) with freshly sampled dimensions in the same cycle.
    assign w_cur_col  = w_good_sof ? '0 : r_col;
    assign w_cur_row  = w_good_sof ? '0 : r_row;
    assign w_w_last   = w_good_sof ? bus.img_width - C_ONE  : r_w_last;
    assign w_h_last   = w_good_sof ? bus.img_height - C_ONE : r_h_last;
    assign w_last_col = (w_cur_col == w_w_last);
    assign w_last_pix = w_last_col && (w_cur_row == w_h_last);

    assign w_addr   = LB_AW'(w_cur_col);
    assign w_lb_old = r_lb_old[w_addr];
    assign w_lb_mid = r_lb_mid[w_addr];

    // NOTE: line buffers carry no reset so they map onto RAM; rows 0/1 of every frame overwrite them before any valid window reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb_old[w_addr] <= w_lb_mid;
            r_lb_mid[w_addr] <= bus.pix_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_w_last      <= '0;
            r_h_last      <= '0;
            r_window      <= '0;
            r_win_advance <= 1'b0;
            r_win_valid   <= 1'b0;
            r_win_x       <= '0;
            r_win_y       <= '0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_win_advance <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= w_bad_sof || (w_good_sof && r_state == ACTIVE);

            if (w_bad_sof) begin
                r_state <= IDLE;
            end else if (w_accept) begin
                r_state  <= w_last_pix ? IDLE : ACTIVE;
                r_w_last <= w_w_last;
                r_h_last <= w_h_last;
                r_col    <= w_last_col ? '0 : w_cur_col + C_ONE;
                r_row    <= w_last_col ? w_cur_row + C_ONE : w_cur_row;

                for (int r = 0; r < 3; r++) begin
                    r_window[r][0] <= r_window[r][1];
                    r_window[r][1] <= r_window[r][2];
                end
                r_window[0][2] <= w_lb_old;
                r_window[1][2] <= w_lb_mid;
                r_window[2][2] <= bus.pix_data;

                r_win_advance <= 1'b1;
                r_win_valid   <= (w_cur_row >= COORD_BITS'(2)) && (w_cur_col >= COORD_BITS'(2));
                r_win_x       <= w_cur_col - C_ONE;
                r_win_y       <= w_cur_row - C_ONE;
                r_frame_done  <= w_last_pix;
            end
        end
    end

    assign bus.window      = r_window;
    assign bus.win_advance = r_win_advance;
    assign bus.win_valid   = r_win_valid;
    assign bus.win_x       = r_win_x;
    assign bus.win_y       = r_win_y;
    assign bus.frame_done  = r_frame_done;
    assign bus.sync_err    = r_sync_err;
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream neighbour of the Harris matrix stage.
- Accepts a raster-order luma pixel stream and buffers two previous image lines.
- Presents a registered 3x3 neighbourhood each time a pixel is accepted, plus an advance strobe that directly drives the Harris stage's advance input.
- Flags which windows lie fully inside the image and tracks frame boundaries.

Parameters:
- LUMA_BITS, 8, pixel width.
- MAX_WIDTH, 640, line-buffer depth; largest supported image width.
- COORD_BITS, 10, width of coordinate, width and height values.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- img_width  input  COORD_BITS  line length; sampled on the SOF pixel.
- img_height  input  COORD_BITS  line count; sampled on the SOF pixel.
- pix_valid  input  1  pixel present this cycle.
- pix_sof  input  1  qualifies pixel (0,0); meaningful only with pix_valid.
- pix_data  input  LUMA_BITS  unsigned luma.
- window  output  LUMA_BITS x [3][3]  window[row][col]; row 0 = y-1, col 0 = x-1, col 2 = newest pixel.
- win_advance  output  1  one-cycle pulse: window updated.
- win_valid  output  1  current window fully inside the image.
- win_x, win_y  output  COORD_BITS each  centre coordinates of the current window.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.
- sync_err  output  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE; col and row counters clear.
  - window, win_* outputs, frame_done and sync_err all clear to 0.
  - Line buffers are not reset. Stale contents never reach a valid window.
- Reset mid-frame discards the frame. Streaming restarts only on a new SOF.
- An accepted pixel means pix_valid=1 in the ACTIVE state, or an SOF pixel in any state.
- IDLE state:
  - Pixels without SOF are dropped silently.
  - An SOF pixel with 3<=img_width<=MAX_WIDTH and img_height>=3 latches width and height, is processed as (0,0), and moves the block to ACTIVE.
  - An SOF pixel with out-of-range width or height pulses sync_err, keeps the block in IDLE, and is dropped.
- ACTIVE state:
  - Each accepted pixel at (col,row) forms a new column {lb_old[col], lb_mid[col], pix_data}.
  - The line buffers are read before they are written, then updated: lb_old[col]<=lb_mid[col], lb_mid[col]<=pix_data.
  - The window shifts left: col0<=col1, col1<=col2, col2<=new column (top to bottom = rows 0..2).
  - col increments; at width-1 it wraps to 0 and row increments.
- Output timing:
  - All outputs are registered. Latency is 1 cycle from an accepted pixel to win_advance=1 with the updated window.
  - Cycles without an accepted pixel hold window, win_x, win_y and win_valid, with win_advance=0.
  - Arbitrary gaps in pix_valid are legal.
- Validity and coordinates:
  - win_valid=1 iff the accepted pixel had row>=2 and col>=2. Row-wrap windows at col 0/1 are invalid.
  - win_x=col-1 and win_y=row-1, registered with the window. They are meaningful only when win_valid=1.
- End of frame:
  - The pixel at (width-1, height-1) produces its window normally.
  - frame_done pulses on the same cycle as that window's win_advance.
  - The state returns to IDLE.
- SOF received while ACTIVE:
  - sync_err pulses; the frame is aborted.
  - The new SOF pixel is treated as (0,0) of a new frame, with fresh width and height sampled in that same cycle.
  - Its window has win_valid=0.
- Arithmetic: there is no arithmetic on pixel data. Counters compare against latched width-1 and height-1.
- Line buffers: two MAX_WIDTH x LUMA_BITS arrays, one read and one write per accepted pixel. They are RAM-inferable.

Test Plan:
- 5x4 image, pix=row*16+col, continuous valid:
  - At the accepted pixel (2,2): window rows = {00,01,02},{10,11,12},{20,21,22}; win_x=1, win_y=1; win_valid=1 one cycle later.
  - Exactly 6 valid windows.
  - frame_done coincides with the (4,3) window.
- Same image with random 0-3 idle cycles between pixels:
  - Identical window sequence to the continuous case.
  - win_advance count = 20.
  - Outputs held during gaps.
- Mid-frame SOF at (2,1) of a 5x4 frame, then a full 6x3 frame:
  - One sync_err pulse.
  - New frame yields 4 valid windows, first with centre (1,1), using only new-frame data.
- SOF with img_width=2, and separately img_width=MAX_WIDTH+1:
  - sync_err pulse; stays IDLE.
  - Following non-SOF pixels produce no win_advance.
- reset_n asserted mid-frame:
  - All outputs are 0 immediately.
  - Non-SOF pixels ignored until SOF.
  - Next 5x4 frame matches the first scenario.
- MAX_WIDTH-wide, 3-line image, pix=col[7:0]: valid windows at win_y=1 only, win_x 1..MAX_WIDTH-2, correct wrap of col values.
